alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, operand/result width in bits (legal >= 2).
REQ-002 The block SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid  input  1  operation offered.
REQ-005 The block SHALL have port in_ready  output  1  operation accepted when in_valid & in_ready.
REQ-006 The block SHALL have ports Ain, Bin  input  WIDTH  operands.
REQ-007 The block SHALL have port ALUop  input  2  operation code (alu_op_e).
REQ-008 The block SHALL have port loads  input  1  update status register when this op retires.
REQ-009 The block SHALL have port out_valid  output  1  result valid.
REQ-010 The block SHALL have port out_ready  input  1  consumer accepts result when out_valid & out_ready.
REQ-011 The block SHALL have port out  output  WIDTH  registered result.
REQ-012 The block SHALL have port flags  output  3  {Z,V,N} of the result on out, valid with out_valid.
REQ-013 The block SHALL have port status  output  3  {Z,V,N} status register.

Function
REQ-014 Ops SHALL be: 00 ADD Ain+Bin; 01 SUB Ain-Bin; 10 AND Ain&Bin; 11 NOTB ~Bin; all modulo 2^WIDTH.
REQ-015 Z SHALL be 1 iff result == 0; N SHALL be result[WIDTH-1].
REQ-016 V for ADD SHALL be 1 iff Ain and Bin MSBs equal and the pre-saturation result MSB differs from Ain MSB.
REQ-017 V for SUB SHALL be 1 iff Ain and Bin MSBs differ and the pre-saturation result MSB differs from Ain MSB; V SHALL be 0 for AND/NOTB.
REQ-018 Pipeline SHALL have two register stages: S1 captures Ain/Bin/ALUop/loads; S2 captures result, flags, loads tag.
REQ-019 Latency from input transfer to out_valid SHALL be exactly 2 cycles when out_ready stays high; throughput one op per cycle.
REQ-020 S2 SHALL advance when !s2_valid | out_ready; S1 SHALL advance when !s1_valid | S2 advancing; in_ready SHALL equal the S1 advance condition (combinational, no dependency on in_valid).
REQ-021 While out_valid & !out_ready, out, flags and out_valid SHALL hold stable; no op is dropped or duplicated.
REQ-022 An S1 bubble SHALL be squeezed out: with S2 stalled and S1 empty, one new op SHALL be accepted.
REQ-023 status SHALL load S2 flags on the cycle an output transfer occurs with the S2 loads tag set; otherwise hold.
REQ-024 Results SHALL retire in acceptance order.

Reset
REQ-025 On reset, s1_valid, out_valid SHALL be 0, out SHALL be 0, flags SHALL be 3'b000, status SHALL be 3'b000; in_ready SHALL be 1 the cycle after reset deasserts.
REQ-026 Reset mid-operation SHALL discard all in-flight ops with no status update; reset dominates simultaneous transfers.

Configuration
REQ-027 With ALU_PIPE_SAT_EN defined, ADD/SUB with V=1 SHALL return signed saturation (max 0111..1 if Ain MSB=0, min 1000..0 if Ain MSB=1); Z/N SHALL reflect the saturated value, V SHALL remain 1.
REQ-028 Without ALU_PIPE_SAT_EN, ADD/SUB SHALL wrap modulo 2^WIDTH; no saturation logic present.

Structure
REQ-029 Package alu_pkg SHALL hold typedef alu_op_e (ADD=2'b00, SUB=2'b01, AND=2'b10, NOTB=2'b11) and status bit index constants Z_BIT=2, V_BIT=1, N_BIT=0.
REQ-030 Combinational arithmetic and flag generation SHALL live in sub-module alu_core (parameter WIDTH), instantiated once in the S1->S2 path.

Verification
REQ-031 WIDTH=16, ADD 16'h7FFF+16'h0001, out_ready=1 -> 2 cycles later out=16'h8000, flags=3'b011 (with SAT_EN: out=16'h7FFF, flags=3'b010).
REQ-032 SUB 16'h0005-16'h0005 with loads=1 -> out=0, flags=3'b100, status=3'b100 after transfer; following AND with loads=0 leaves status 3'b100.
REQ-033 Back-to-back 8 ops, out_ready held low 3 cycles mid-stream -> in_ready drops once both stages full, all 8 results in order, out stable during stall.
REQ-034 NOTB Bin=16'h00FF -> out=16'hFF00, flags=3'b001; AND 16'hF0F0&16'h0F0F -> out=0, flags=3'b100.
REQ-035 Reset asserted with two ops in flight -> next cycle out_valid=0, status=3'b000, no retirement of discarded ops.
REQ-036 WIDTH=8, SUB 8'h80-8'h01 -> out=8'h7F, V=1 (SAT_EN: out=8'h80, flags=3'b011).

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU opcode encoding and {Z,V,N} status bit positions for alu_pipe.
package alu_pkg;

    typedef enum logic [1:0] {
        ADD  = 2'b00,
        SUB  = 2'b01,
        AND  = 2'b10,
        NOTB = 2'b11
    } alu_op_e;

    localparam int Z_BIT = 2;
    localparam int V_BIT = 1;
    localparam int N_BIT = 0;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath with {Z,V,N} flag generation.
// Optional signed saturation on ADD/SUB overflow when ALU_PIPE_SAT_EN is defined.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] res,
    output logic [2:0]       flg
);

    logic [WIDTH-1:0] raw;
    logic             ovf;

    always_comb begin
        raw = '0;
        ovf = 1'b0;
        unique case (op)
            ADD: begin
                raw = a + b;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
            end
            SUB: begin
                raw = a - b;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
            end
            AND:  raw = a & b;
            NOTB: raw = ~b;
            default: ;
        endcase
    end

`ifdef ALU_PIPE_SAT_EN
    // Overflow always lands on the side of Ain's sign, so clamp toward it.
    logic [WIDTH-1:0] sat_val;
    assign sat_val = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    assign res     = ovf ? sat_val : raw;
`else
    assign res = raw;
`endif

    always_comb begin
        flg        = '0;
        flg[Z_BIT] = (res == '0);
        flg[V_BIT] = ovf;
        flg[N_BIT] = res[WIDTH-1];
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with retire-time status register.
// Build option: ALU_PIPE_SAT_EN enables signed saturation in alu_core.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Ain,
    input  logic [WIDTH-1:0] Bin,
    input  logic [1:0]       ALUop,
    input  logic             loads,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic [2:0]       flags,
    output logic [2:0]       status
);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        alu_op_e          op;
        logic             loads;
    } s1_req_t;

    s1_req_t          s1;
    logic             s1_valid;
    logic             s2_loads;
    logic             s2_adv;
    logic             s1_adv;
    logic [WIDTH-1:0] core_res;
    logic [2:0]       core_flg;

    // Each stage moves when its successor is empty or draining this cycle,
    // which also lets a new op fill an S1 bubble behind a stalled S2.
    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a   (s1.a),
        .b   (s1.b),
        .op  (s1.op),
        .res (core_res),
        .flg (core_flg)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s1        <= '0;
            s1_valid  <= 1'b0;
            out_valid <= 1'b0;
            out       <= '0;
            flags     <= '0;
            s2_loads  <= 1'b0;
            status    <= '0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1.a     <= Ain;
                    s1.b     <= Bin;
                    s1.op    <= alu_op_e'(ALUop);
                    s1.loads <= loads;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    out      <= core_res;
                    flags    <= core_flg;
                    s2_loads <= s1.loads;
                end
            end
            if (out_valid && out_ready && s2_loads)
                status <= flags;
        end
    end

endmodule
